// File: rtl/window_pkg.sv
// Shared types and helpers for the sliding-window buffer: FSM state and
// the tap-index mapping used to pack the window onto a flat bus.
package window_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Flat position of tap (r,c) in a win x win window, row-major, r=0 oldest row.
  function automatic int tap_idx(input int r, input int c, input int win);
    return r * win + c;
  endfunction

endpackage

// File: rtl/window_buffer_if.sv
// Pixel stream in, window stream out. The master drives pixels and the
// slave (window_buffer) returns windows and framing pulses.
interface window_buffer_if #(
  parameter int DATA_WIDTH   = 12,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int WIN          = 3
);
  localparam int XW = $clog2(LINE_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);

  logic [DATA_WIDTH-1:0]         pixel_in;
  logic                          pixel_valid;
  logic                          sof;
  logic [WIN*WIN*DATA_WIDTH-1:0] win_data;
  logic                          win_valid;
  logic [XW-1:0]                 win_x;
  logic [YW-1:0]                 win_y;
  logic                          frame_done;
  logic                          frame_err;

  modport master (
    output pixel_in, pixel_valid, sof,
    input  win_data, win_valid, win_x, win_y, frame_done, frame_err
  );

  modport slave (
    input  pixel_in, pixel_valid, sof,
    output win_data, win_valid, win_x, win_y, frame_done, frame_err
  );

endinterface

// File: rtl/line_delay.sv
// One line of pixel delay: a circular buffer whose read slot is the slot
// about to be overwritten, so dout is din from LINE_WIDTH enabled cycles ago.
module line_delay #(
  parameter int DATA_WIDTH = 12,
  parameter int LINE_WIDTH = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] mem [LINE_WIDTH];
  logic [AW-1:0]         ptr;

  assign dout = mem[ptr];

  // NOTE: the line store has no reset so it maps onto plain RAM; the frame
  // row counter guarantees stale contents never reach a valid window.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  // NOTE: clocked state is written only with <= so every register sees
  // pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(LINE_WIDTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/window_buffer.sv
// WIN x WIN sliding window over a raster pixel stream, with frame tracking
// (sof / frame_done / frame_err) and interior-only window emission.
module window_buffer
  import window_pkg::*;
#(
  parameter int DATA_WIDTH   = 12,
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int WIN          = 3
) (
  input logic             clk,
  input logic             rst,
  window_buffer_if.slave  bus
);
  localparam int R  = (WIN - 1) / 2;
  localparam int XW = $clog2(LINE_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);

  state_t          state;
  logic [XW-1:0]   col, cur_col;
  logic [YW-1:0]   row, cur_row;
  logic            store, at_line_end, at_frame_end, win_hit;

  logic            win_valid_q, frame_done_q, frame_err_q;
  logic [XW-1:0]   win_x_q;
  logic [YW-1:0]   win_y_q;

  // line_tap[0] is the incoming pixel, line_tap[k] the same column k lines up.
  logic [DATA_WIDTH-1:0]         line_tap [WIN];
  logic [DATA_WIDTH-1:0]         win_q    [WIN][WIN];
  logic [WIN*WIN*DATA_WIDTH-1:0] win_flat;

  // NOTE: every always_comb output is assigned on every path, so no latch
  // is inferred.
  always_comb begin
    store        = bus.pixel_valid && (bus.sof || state == ACTIVE);
    cur_col      = bus.sof ? '0 : col;
    cur_row      = bus.sof ? '0 : row;
    at_line_end  = (cur_col == XW'(LINE_WIDTH - 1));
    at_frame_end = at_line_end && (cur_row == YW'(FRAME_HEIGHT - 1));
    win_hit      = (cur_col >= XW'(WIN - 1)) && (cur_row >= YW'(WIN - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      win_valid_q  <= store && win_hit;
      frame_done_q <= store && at_frame_end;
      // Pixel without sof while idle, or sof while a frame is in flight.
      frame_err_q  <= bus.pixel_valid &&
                      ((state == IDLE && !bus.sof) || (state == ACTIVE && bus.sof));
      if (store) begin
        if (win_hit) begin
          win_x_q <= cur_col - XW'(R);
          win_y_q <= cur_row - YW'(R);
        end
        if (at_frame_end) begin
          state <= IDLE;
          col   <= '0;
          row   <= '0;
        end else begin
          state <= ACTIVE;
          if (at_line_end) begin
            col <= '0;
            row <= cur_row + YW'(1);
          end else begin
            col <= cur_col + XW'(1);
            row <= cur_row;
          end
        end
      end
    end
  end

  assign line_tap[0] = bus.pixel_in;

  for (genvar k = 0; k < WIN - 1; k++) begin : g_line
    line_delay #(
      .DATA_WIDTH (DATA_WIDTH),
      .LINE_WIDTH (LINE_WIDTH)
    ) u_line_delay (
      .clk  (clk),
      .rst  (rst),
      .en   (store),
      .din  (line_tap[k]),
      .dout (line_tap[k+1])
    );
  end

  // Each window row shifts left; column WIN-1 takes the newest pixel of its line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (store) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][WIN-1] <= line_tap[WIN-1-r];
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_flat[tap_idx(r, c, WIN)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
      end
    end
  end

  assign bus.win_data   = win_flat;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_x      = win_x_q;
  assign bus.win_y      = win_y_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer: one WIN=3 and one WIN=5 instance on an
// 8x6 frame, both fed the same pixel stream (pixel = row*16 + col).
module tb_window_buffer;
  localparam int DW = 12;
  localparam int LW = 8;
  localparam int FH = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_buffer_if #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .WIN(3)) bus3 ();
  window_buffer_if #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .WIN(5)) bus5 ();

  window_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .WIN(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  window_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .WIN(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  int total = 0;
  int bad   = 0;
  int win_cnt3, win_cnt5, done_cnt, err_cnt;
  int last_col = -1;
  int last_row = -1;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected window for a centre-bottom-right pixel (col,row) in a w x w window.
  function automatic logic [319:0] exp_win(input int w, input int col, input int row);
    logic [319:0] v;
    v = '0;
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        v[(r*w + c)*DW +: DW] = 12'((row - (w-1) + r)*16 + (col - (w-1) + c));
      end
    end
    return v;
  endfunction

  task automatic clear_counts();
    win_cnt3 = 0;
    win_cnt5 = 0;
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic drive(input logic [DW-1:0] pix, input logic vld, input logic s);
    bus3.pixel_in = pix;  bus3.pixel_valid = vld;  bus3.sof = s;
    bus5.pixel_in = pix;  bus5.pixel_valid = vld;  bus5.sof = s;
  endtask

  // One clock with the given inputs; outputs sampled 1 ns after the edge.
  task automatic step(input logic [DW-1:0] pix, input logic vld, input logic s);
    drive(pix, vld, s);
    @(posedge clk);
    #1;
    if (bus3.win_valid)  win_cnt3++;
    if (bus5.win_valid)  win_cnt5++;
    if (bus3.frame_done) done_cnt++;
    if (bus3.frame_err)  err_cnt++;
  endtask

  task automatic send_pixel(input int col, input int row, input logic s, input logic exp_err);
    logic v3, v5;
    step(12'(row*16 + col), 1'b1, s);
    v3 = (col >= 2) && (row >= 2);
    v5 = (col >= 4) && (row >= 4);
    check($sformatf("valid3 (%0d,%0d)", col, row), bus3.win_valid, v3);
    if (v3) begin
      check($sformatf("data3 (%0d,%0d)", col, row), bus3.win_data, exp_win(3, col, row));
      check($sformatf("x3 (%0d,%0d)", col, row), bus3.win_x, col - 1);
      check($sformatf("y3 (%0d,%0d)", col, row), bus3.win_y, row - 1);
    end
    check($sformatf("valid5 (%0d,%0d)", col, row), bus5.win_valid, v5);
    if (v5) begin
      check($sformatf("data5 (%0d,%0d)", col, row), bus5.win_data, exp_win(5, col, row));
      check($sformatf("x5 (%0d,%0d)", col, row), bus5.win_x, col - 2);
      check($sformatf("y5 (%0d,%0d)", col, row), bus5.win_y, row - 2);
    end
    check($sformatf("done (%0d,%0d)", col, row), bus3.frame_done, (col == LW-1) && (row == FH-1));
    check($sformatf("err (%0d,%0d)", col, row), bus3.frame_err, exp_err);
    last_col = col;
    last_row = row;
  endtask

  // Idle cycle with junk on the data lines: nothing may move.
  task automatic gap();
    step(12'($urandom_range(0, 4095)), 1'b0, 1'($urandom_range(0, 1)));
    check("gap valid3", bus3.win_valid, 1'b0);
    check("gap valid5", bus5.win_valid, 1'b0);
    check("gap done", bus3.frame_done, 1'b0);
    check("gap err", bus3.frame_err, 1'b0);
    if (last_col >= 2 && last_row >= 2) begin
      check("gap hold data3", bus3.win_data, exp_win(3, last_col, last_row));
      check("gap hold x3", bus3.win_x, last_col - 1);
    end
    if (last_col >= 4 && last_row >= 4) begin
      check("gap hold data5", bus5.win_data, exp_win(5, last_col, last_row));
    end
  endtask

  // Raster indices first..last of a frame; index 0 carries sof.
  task automatic send_range(input int first, input int last, input logic gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) gap();
      send_pixel(i % LW, i / LW, i == 0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive('0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst valid3", bus3.win_valid, 1'b0);
    check("rst done", bus3.frame_done, 1'b0);
    check("rst err", bus3.frame_err, 1'b0);
    check("rst data3", bus3.win_data, '0);
    check("rst x3", bus3.win_x, '0);
    check("rst y3", bus3.win_y, '0);
    check("rst data5", bus5.win_data, '0);
    rst = 1'b1;

    // Continuous frame.
    clear_counts();
    send_range(0, LW*FH - 1, 1'b0);
    check("t1 windows3", win_cnt3, 24);
    check("t1 windows5", win_cnt5, 8);
    check("t1 done count", done_cnt, 1);
    gap();

    // Same frame with random idle cycles.
    clear_counts();
    send_range(0, LW*FH - 1, 1'b1);
    check("t2 windows3", win_cnt3, 24);
    check("t2 windows5", win_cnt5, 8);
    check("t2 done count", done_cnt, 1);

    // sof arriving at (3,2) restarts the frame.
    clear_counts();
    send_range(0, 2*LW + 2, 1'b0);
    send_pixel(0, 0, 1'b1, 1'b1);
    send_range(1, LW*FH - 1, 1'b0);
    check("t3 windows3", win_cnt3, 25);
    check("t3 windows5", win_cnt5, 8);
    check("t3 err count", err_cnt, 1);
    check("t3 done count", done_cnt, 1);

    // Three pixels before sof are dropped with errors.
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      step(12'(16 + i), 1'b1, 1'b0);
      check($sformatf("t4 err %0d", i), bus3.frame_err, 1'b1);
      check($sformatf("t4 valid %0d", i), bus3.win_valid, 1'b0);
    end
    send_range(0, LW*FH - 1, 1'b0);
    check("t4 err count", err_cnt, 3);
    check("t4 windows3", win_cnt3, 24);
    check("t4 done count", done_cnt, 1);

    // Asynchronous reset at (5,3), then resume without sof.
    clear_counts();
    send_range(0, 3*LW + 4, 1'b0);
    drive(12'(3*16 + 5), 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("async valid3", bus3.win_valid, 1'b0);
    check("async data3", bus3.win_data, '0);
    check("async x3", bus3.win_x, '0);
    check("async y3", bus3.win_y, '0);
    check("async done", bus3.frame_done, 1'b0);
    check("async err", bus3.frame_err, 1'b0);
    check("async data5", bus5.win_data, '0);
    @(posedge clk);
    #1;
    check("held rst valid3", bus3.win_valid, 1'b0);
    rst = 1'b1;
    clear_counts();
    for (int i = 3*LW + 6; i < 5*LW + 1; i++) begin
      step(12'((i / LW)*16 + i % LW), 1'b1, 1'b0);
      check($sformatf("t5 err %0d", i), bus3.frame_err, 1'b1);
    end
    check("t5 err count", err_cnt, 11);
    check("t5 windows3", win_cnt3, 0);
    check("t5 windows5", win_cnt5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 12, pixel width in bits.
REQ-002 Parameter LINE_WIDTH, default 640, pixels per line.
REQ-003 Parameter FRAME_HEIGHT, default 480, lines per frame.
REQ-004 Parameter WIN, default 3, window edge length; odd, 3..7; R = (WIN-1)/2.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 pixel_in  input  DATA_WIDTH  grayscale pixel.
REQ-008 pixel_valid  input  1  pixel_in accepted this cycle when high.
REQ-009 sof  input  1  start of frame; qualified by pixel_valid, marks pixel (0,0).
REQ-010 win_data  output  WIN*WIN*DATA_WIDTH  window; tap (r,c) at bits [(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 top (oldest) row, c=0 leftmost.
REQ-011 win_valid  output  1  win_data/win_x/win_y valid this cycle.
REQ-012 win_x  output  clog2(LINE_WIDTH)  column of window centre.
REQ-013 win_y  output  clog2(FRAME_HEIGHT)  row of window centre.
REQ-014 frame_done  output  1  one-cycle pulse, frame complete.
REQ-015 frame_err  output  1  one-cycle pulse, framing violation.

Function
REQ-016 FSM states IDLE, ACTIVE; reset to IDLE.
REQ-017 IDLE: pixel_valid&sof -> store pixel as (0,0), enter ACTIVE; pixel_valid&!sof -> pixel dropped, frame_err pulse.
REQ-018 ACTIVE: each accepted pixel advances col; col wraps LINE_WIDTH-1 -> 0 and increments row.
REQ-019 Accepting pixel (LINE_WIDTH-1, FRAME_HEIGHT-1) -> frame_done pulse next cycle, enter IDLE.
REQ-020 sof accepted in ACTIVE -> frame_err pulse, pixel taken as new (0,0), counters restart; no window spans both frames.
REQ-021 Storage: WIN-1 line delays of LINE_WIDTH entries plus WIN x WIN window register; all shift only on accepted pixels.
REQ-022 Pixel accepted at (col,row) on cycle t -> cycle t+1 win_valid high iff col>=WIN-1 and row>=WIN-1 (interior centres only).
REQ-023 At that cycle win_x = col-R, win_y = row-R, tap (r,c) = pixel(col-(WIN-1)+c, row-(WIN-1)+r).
REQ-024 Windows never combine pixels from two lines: taps beyond line start suppressed via col gating, not data clearing.
REQ-025 Windows per frame = (LINE_WIDTH-2R)*(FRAME_HEIGHT-2R).
REQ-026 pixel_valid low: win_valid low next cycle; win_data, win_x, win_y, counters, storage hold.
REQ-027 frame_done and frame_err may assert in the same cycle only on sof at last pixel position (treated as REQ-020; no frame_done).
REQ-028 Line memory contents after restart are don't-care; row gating guarantees no stale window is emitted.

Reset
REQ-029 rst low: state IDLE, col=row=0, win_valid=0, frame_done=0, frame_err=0, win_data=0, win_x=0, win_y=0, immediately and asynchronously.
REQ-030 Reset mid-frame discards the frame; first post-reset window requires new sof.
REQ-031 Line-delay storage need not be cleared on reset.

Structure
REQ-032 Shared package window_pkg holds FSM state enum and tap-index helper function.
REQ-033 Sub-module line_delay (LINE_WIDTH deep, DATA_WIDTH wide, enable-gated shift) instantiated WIN-1 times.

Verification (DATA_WIDTH=12, LINE_WIDTH=8, FRAME_HEIGHT=6, WIN=3, pixel = row*16+col unless noted)
REQ-034 Continuous frame -> first win_valid cycle after pixel (2,2): win_x=1, win_y=1, tap(0,0)=0x000, tap(1,1)=0x011, tap(2,2)=0x022; 24 windows total; frame_done cycle after (7,5).
REQ-035 Same frame, pixel_valid randomly low 50% -> identical 24-window sequence; outputs held during gaps.
REQ-036 sof at position (3,2) -> frame_err pulse; next window only after new (2,2), tap(0,0)=0x000.
REQ-037 Three pixels before sof -> three frame_err pulses, no windows, frame then processed per REQ-034.
REQ-038 rst low at pixel (5,3) -> all outputs 0 next sample; resume without sof -> frame_err, no windows.
REQ-039 WIN=5 -> first window after pixel (4,4), win_x=2, win_y=2, tap(4,4)=0x044; 8 windows per frame.
